fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  decode stage holding; F_* outputs SHALL not change while asserted.
REQ-005 jb  input  1  jump/branch redirect request.
REQ-006 jb_pc  input  32  redirect target; bits [1:0] forced to 0.
REQ-007 imem_req  output  1  one-cycle instruction-memory request pulse.
REQ-008 imem_addr  output  32  request address; valid while imem_req=1.
REQ-009 imem_rvalid  input  1  response strobe, at least 1 cycle after imem_req.
REQ-010 imem_rdata  input  32  instruction word; valid with imem_rvalid.
REQ-011 F_pc  output  32  PC of presented instruction, registered.
REQ-012 F_inst  output  32  presented instruction, registered.
REQ-013 F_valid  output  1  F_pc/F_inst hold a real instruction.

Function
REQ-014 FSM states IDLE, REQ, WAIT, HOLD; at most one outstanding memory request.
REQ-015 IDLE -> REQ unconditionally on the cycle after reset release.
REQ-016 REQ: imem_req=1, imem_addr=pc for exactly one cycle, then -> WAIT.
REQ-017 WAIT, rvalid=1, kill=0, (stall=0 or F_valid=0): F_pc<=pc, F_inst<=rdata, F_valid<=1, pc<=pc+4 (mod 2^32), -> REQ.
REQ-018 WAIT, rvalid=1, kill=0, stall=1, F_valid=1: rdata/pc captured into 1-entry hold buffer, pc<=pc+4, -> HOLD.
REQ-019 HOLD: on stall=0, buffer moves to F_* with F_valid=1, -> REQ; otherwise remain.
REQ-020 F_* consumed on any cycle with stall=0 and F_valid=1; if no new capture that cycle, F_valid<=0, F_inst<=32'h0000_0013 (NOP), F_pc<=0.
REQ-021 jb=1 has priority over stall and SHALL: pc<=jb_pc, flush F_* to NOP/F_valid=0, discard hold buffer.
REQ-022 jb in REQ: imem_req suppressed that cycle, stay REQ. jb in WAIT without rvalid: kill<=1, stay WAIT. jb in WAIT with rvalid: response dropped, -> REQ. jb in HOLD: -> REQ.
REQ-023 WAIT, rvalid=1, kill=1: response dropped, kill<=0, pc unchanged, -> REQ.
REQ-024 First instruction delivered after a redirect SHALL have F_pc equal to jb_pc.

Reset
REQ-025 rst_n=0 SHALL immediately set state=IDLE, pc=RESET_PC, kill=0, hold buffer empty, imem_req=0, imem_addr=0, F_valid=0, F_pc=0, F_inst=32'h0000_0013.
REQ-026 Reset asserted mid-WAIT SHALL discard the outstanding request; any later rvalid before the first new REQ SHALL be ignored.

Configuration
REQ-027 Macro FETCH_PERF_EN defined: outputs perf_fetch_cnt[31:0] (increments per instruction entering F_*) and perf_kill_cnt[31:0] (increments per dropped response or flushed valid instruction), both wrap, reset to 0.
REQ-028 FETCH_PERF_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-029 Shared package pipe_pkg SHALL hold NOP_INST (32'h0000_0013), default RESET_PC, and the fetch FSM state enum.
REQ-030 Counters SHALL live in sub-module fetch_perf, instantiated only under FETCH_PERF_EN; next-PC logic stays flat in fetch_unit.

Verification
REQ-031 Reset release, 1-cycle memory, stall=0 -> requests at 0x0,0x4,0x8; F_pc sequence 0x0,0x4,0x8 with matching rdata.
REQ-032 stall=1 for 5 cycles while F_valid=1 and response arrives -> F_* unchanged; HOLD entered; after stall=0, buffered 0x4 instruction appears next cycle, no loss or duplicate.
REQ-033 jb=1, jb_pc=0x100 in WAIT with 3-cycle memory -> stale response dropped; next imem_addr=0x100; F_pc=0x100.
REQ-034 jb and rvalid same cycle -> response dropped, F_inst=0x13, F_valid=0, next request 0x100.
REQ-035 pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
REQ-036 rst_n low during WAIT, stray rvalid afterwards -> ignored; first request after release at RESET_PC; with FETCH_PERF_EN counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the NOP encoding, the default reset PC and the
// fetch FSM state type.
package pipe_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2,
        FS_HOLD = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_perf.sv
// Fetch performance counters: instructions delivered to F_* and instructions
// killed (dropped responses or flushed valid entries). Both wrap.
module fetch_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc,
    input  logic [1:0]  kill_inc,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_kill_cnt
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] kill_cnt_q,  kill_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_inc};
        kill_cnt_d  = kill_cnt_q + {30'd0, kill_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            kill_cnt_q  <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_kill_cnt  = kill_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with a one-entry hold buffer and
// jump/branch redirect. Define FETCH_PERF_EN to add the performance counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FS_IDLE | one cycle after reset release, nothing outstanding
// FS_REQ  | issue imem request for pc (suppressed if jb this cycle)
// FS_WAIT | request outstanding; kill_q marks a response to be dropped
// FS_HOLD | response parked in hold buffer while decode stalls
module fetch_unit
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jb,
    input  logic [31:0] jb_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] F_pc,
    output logic [31:0] F_inst,
    output logic        F_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_kill_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic         hold_valid_q, hold_valid_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic [31:0]  hold_inst_q, hold_inst_d;
    logic         f_valid_q, f_valid_d;
    logic [31:0]  f_pc_q, f_pc_d;
    logic [31:0]  f_inst_q, f_inst_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        hold_valid_d = hold_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_inst_d  = hold_inst_q;
        f_valid_d    = f_valid_q;
        f_pc_d       = f_pc_q;
        f_inst_d     = f_inst_q;

        // Decode takes the presented entry; a capture below may refill it.
        if (f_valid_q && !stall) begin
            f_valid_d = 1'b0;
            f_pc_d    = 32'd0;
            f_inst_d  = NOP_INST;
        end

        if (jb) begin
            pc_d         = align_pc(jb_pc);
            f_valid_d    = 1'b0;
            f_pc_d       = 32'd0;
            f_inst_d     = NOP_INST;
            hold_valid_d = 1'b0;
            unique case (state_q)
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = FS_REQ;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                default: begin
                    kill_d  = 1'b0;
                    state_d = FS_REQ;
                end
            endcase
        end else begin
            unique case (state_q)
                FS_IDLE: state_d = FS_REQ;
                FS_REQ:  state_d = FS_WAIT;
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = FS_REQ;
                        if (kill_q) begin
                            kill_d = 1'b0;
                        end else if (!stall || !f_valid_q) begin
                            f_valid_d = 1'b1;
                            f_pc_d    = pc_q;
                            f_inst_d  = imem_rdata;
                            pc_d      = pc_q + 32'd4;
                        end else begin
                            hold_valid_d = 1'b1;
                            hold_pc_d    = pc_q;
                            hold_inst_d  = imem_rdata;
                            pc_d         = pc_q + 32'd4;
                            state_d      = FS_HOLD;
                        end
                    end
                end
                FS_HOLD: begin
                    if (!stall) begin
                        f_valid_d    = 1'b1;
                        f_pc_d       = hold_pc_q;
                        f_inst_d     = hold_inst_q;
                        hold_valid_d = 1'b0;
                        state_d      = FS_REQ;
                    end
                end
                default: state_d = FS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FS_IDLE;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_pc_q    <= 32'd0;
            hold_inst_q  <= NOP_INST;
            f_valid_q    <= 1'b0;
            f_pc_q       <= 32'd0;
            f_inst_q     <= NOP_INST;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            hold_valid_q <= hold_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_inst_q  <= hold_inst_d;
            f_valid_q    <= f_valid_d;
            f_pc_q       <= f_pc_d;
            f_inst_q     <= f_inst_d;
        end
    end

    assign imem_req  = (state_q == FS_REQ) && !jb;
    assign imem_addr = imem_req ? pc_q : 32'd0;
    assign F_valid   = f_valid_q;
    assign F_pc      = f_pc_q;
    assign F_inst    = f_inst_q;

`ifdef FETCH_PERF_EN
    logic       fetch_inc;
    logic [1:0] kill_inc;

    // A redirect can kill a response and a presented entry in the same cycle.
    always_comb begin
        fetch_inc = 1'b0;
        kill_inc  = 2'd0;
        if (jb) begin
            kill_inc = {1'b0, (state_q == FS_WAIT) && imem_rvalid}
                     + {1'b0, f_valid_q && stall}
                     + {1'b0, hold_valid_q};
        end else begin
            fetch_inc = ((state_q == FS_WAIT) && imem_rvalid && !kill_q && (!stall || !f_valid_q))
                     || ((state_q == FS_HOLD) && !stall);
            kill_inc  = {1'b0, (state_q == FS_WAIT) && imem_rvalid && kill_q};
        end
    end

    fetch_perf u_fetch_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_inc      (fetch_inc),
        .kill_inc       (kill_inc),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_kill_cnt  (perf_kill_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against a program-order model of the delivered instruction stream.
module tb_fetch_unit;
    import pipe_pkg::*;

    localparam logic [31:0] TB_RESET_PC = DEFAULT_RESET_PC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        jb;
    logic [31:0] jb_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] F_pc;
    logic [31:0] F_inst;
    logic        F_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_kill_cnt;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          mem_lat = 1;
    bit          mem_rand = 1'b0;
    logic [31:0] req_log[$];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .jb          (jb),
        .jb_pc       (jb_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .F_pc        (F_pc),
        .F_inst      (F_inst),
        .F_valid     (F_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_kill_cnt  (perf_kill_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd7) ^ 32'h5A00_0000;
    endfunction

    // Memory model: logs each request and answers it after a latency of 1..4.
    initial begin : responder
        bit          mine;
        logic [31:0] a;
        int          l;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        mine        = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (mine) begin
                imem_rvalid = 1'b0;
                mine        = 1'b0;
            end
            #1;
            if (imem_req === 1'b1) begin
                a = imem_addr;
                req_log.push_back(a);
                l = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
                repeat (l) @(negedge clk);
                #1;
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(a);
                mine        = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        stall = 1'b0;
        jb    = 1'b0;
        jb_pc = 32'd0;
        rst_n = 1'b0;
        repeat (6) @(negedge clk);
        req_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_fvalid(input int budget, input string tag);
        for (int i = 0; i < budget && F_valid !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if (F_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_timeout: F_valid=%b required 1", tag, F_valid);
        end
    endtask

    task automatic wait_req(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && req_log.size() < n; i++) @(negedge clk);
        n_cmp++;
        if (req_log.size() < n) begin
            n_err++;
            $display("FAIL %s_req_timeout: requests=%0d required %0d", tag, req_log.size(), n);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp += 5;
        if (F_valid !== 1'b0)        begin n_err++; $display("FAIL rst_fvalid: got %b want 0", F_valid); end
        if (F_pc !== 32'd0)          begin n_err++; $display("FAIL rst_fpc: got %h want 0", F_pc); end
        if (F_inst !== NOP_INST)     begin n_err++; $display("FAIL rst_finst: got %h want %h", F_inst, NOP_INST); end
        if (imem_req !== 1'b0)       begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
        if (imem_addr !== 32'd0)     begin n_err++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", imem_req); end
        @(negedge clk);
        n_cmp += 2;
        if (imem_req !== 1'b1)          begin n_err++; $display("FAIL first_req: got %b want 1", imem_req); end
        if (imem_addr !== TB_RESET_PC)  begin n_err++; $display("FAIL first_addr: got %h want %h", imem_addr, TB_RESET_PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] pcs[$];
        logic [31:0] insts[$];
        logic [31:0] exp_pc;
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 40 && pcs.size() < 3; i++) begin
            if (F_valid === 1'b1) begin
                pcs.push_back(F_pc);
                insts.push_back(F_inst);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (pcs.size() != 3) begin
            n_err++;
            $display("FAIL seq_count: got %0d instructions want 3", pcs.size());
        end
        for (int i = 0; i < pcs.size(); i++) begin
            exp_pc = 32'(4 * i);
            n_cmp += 2;
            if (pcs[i] !== exp_pc)           begin n_err++; $display("FAIL seq_pc%0d: got %h want %h", i, pcs[i], exp_pc); end
            if (insts[i] !== mem_word(exp_pc)) begin n_err++; $display("FAIL seq_inst%0d: got %h want %h", i, insts[i], mem_word(exp_pc)); end
        end
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'(4 * i);
            n_cmp++;
            if (i >= req_log.size() || req_log[i] !== exp_pc) begin
                n_err++;
                $display("FAIL seq_req%0d: got %h want %h", i, (i < req_log.size()) ? req_log[i] : 32'hx, exp_pc);
            end
        end
    endtask

    task automatic test_stall_hold();
        mem_lat = 1;
        do_reset();
        wait_fvalid(20, "hold_first");
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp += 3;
            if (F_valid !== 1'b1)          begin n_err++; $display("FAIL hold_valid%0d: got %b want 1", k, F_valid); end
            if (F_pc !== 32'd0)            begin n_err++; $display("FAIL hold_pc%0d: got %h want 0", k, F_pc); end
            if (F_inst !== mem_word(32'd0)) begin n_err++; $display("FAIL hold_inst%0d: got %h want %h", k, F_inst, mem_word(32'd0)); end
        end
        n_cmp++;
        if (req_log.size() != 2) begin n_err++; $display("FAIL hold_reqs: got %0d requests want 2", req_log.size()); end
        stall = 1'b0;
        @(negedge clk);
        n_cmp += 3;
        if (F_valid !== 1'b1)           begin n_err++; $display("FAIL unhold_valid: got %b want 1", F_valid); end
        if (F_pc !== 32'd4)             begin n_err++; $display("FAIL unhold_pc: got %h want 4", F_pc); end
        if (F_inst !== mem_word(32'd4)) begin n_err++; $display("FAIL unhold_inst: got %h want %h", F_inst, mem_word(32'd4)); end
        @(negedge clk);
        n_cmp++;
        if (F_valid !== 1'b0) begin n_err++; $display("FAIL unhold_dup: F_valid got %b want 0 (pc %h)", F_valid, F_pc); end
        wait_fvalid(20, "unhold_next");
        n_cmp++;
        if (F_pc !== 32'd8) begin n_err++; $display("FAIL unhold_next_pc: got %h want 8", F_pc); end
    endtask

    task automatic test_redirect_wait();
        mem_lat = 3;
        do_reset();
        wait_req(1, 20, "jbwait");
        jb    = 1'b1;
        jb_pc = 32'h0000_0100;
        @(negedge clk);
        jb = 1'b0;
        wait_fvalid(30, "jbwait");
        n_cmp += 3;
        if (F_pc !== 32'h100)             begin n_err++; $display("FAIL jbwait_pc: got %h want 00000100", F_pc); end
        if (F_inst !== mem_word(32'h100)) begin n_err++; $display("FAIL jbwait_inst: got %h want %h", F_inst, mem_word(32'h100)); end
        if (req_log.size() < 2 || req_log[1] !== 32'h100) begin
            n_err++;
            $display("FAIL jbwait_req: got %h want 00000100", (req_log.size() > 1) ? req_log[1] : 32'hx);
        end
    endtask

    task automatic test_jb_with_rvalid();
        mem_lat = 2;
        do_reset();
        wait_fvalid(20, "jbrv_first");
        stall = 1'b1;
        wait_req(2, 10, "jbrv");
        @(negedge clk);
        jb    = 1'b1;
        jb_pc = 32'h0000_0102;
        @(negedge clk);
        jb = 1'b0;
        n_cmp += 2;
        if (F_valid !== 1'b0)    begin n_err++; $display("FAIL jbrv_valid: got %b want 0", F_valid); end
        if (F_inst !== NOP_INST) begin n_err++; $display("FAIL jbrv_inst: got %h want %h", F_inst, NOP_INST); end
        stall = 1'b0;
        wait_req(3, 10, "jbrv_next");
        n_cmp++;
        if (req_log.size() < 3 || req_log[2] !== 32'h100) begin
            n_err++;
            $display("FAIL jbrv_req: got %h want 00000100", (req_log.size() > 2) ? req_log[2] : 32'hx);
        end
        wait_fvalid(20, "jbrv_deliver");
        n_cmp++;
        if (F_pc !== 32'h100) begin n_err++; $display("FAIL jbrv_pc: got %h want 00000100", F_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] pcs[$];
        mem_lat = 1;
        do_reset();
        wait_req(1, 20, "wrap");
        jb    = 1'b1;
        jb_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        jb = 1'b0;
        for (int i = 0; i < 40 && pcs.size() < 2; i++) begin
            if (F_valid === 1'b1) pcs.push_back(F_pc);
            @(negedge clk);
        end
        n_cmp += 2;
        if (pcs.size() < 1 || pcs[0] !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL wrap_pc0: got %h want fffffffc", (pcs.size() > 0) ? pcs[0] : 32'hx);
        end
        if (pcs.size() < 2 || pcs[1] !== 32'h0) begin
            n_err++; $display("FAIL wrap_pc1: got %h want 00000000", (pcs.size() > 1) ? pcs[1] : 32'hx);
        end
        n_cmp++;
        if (req_log.size() < 3 || req_log[2] !== 32'h0) begin
            n_err++; $display("FAIL wrap_req: got %h want 00000000", (req_log.size() > 2) ? req_log[2] : 32'hx);
        end
    endtask

    task automatic test_reset_mid_wait();
        mem_lat = 3;
        do_reset();
        wait_fvalid(20, "rstw_first");
        stall = 1'b1;
        wait_req(2, 10, "rstw");
        #1 rst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (F_valid !== 1'b0)    begin n_err++; $display("FAIL rstw_valid: got %b want 0", F_valid); end
        if (F_pc !== 32'd0)      begin n_err++; $display("FAIL rstw_pc: got %h want 0", F_pc); end
        if (F_inst !== NOP_INST) begin n_err++; $display("FAIL rstw_inst: got %h want %h", F_inst, NOP_INST); end
        if (imem_req !== 1'b0)   begin n_err++; $display("FAIL rstw_req: got %b want 0", imem_req); end
`ifdef FETCH_PERF_EN
        n_cmp += 2;
        if (perf_fetch_cnt !== 32'd0) begin n_err++; $display("FAIL rstw_perf_fetch: got %0d want 0", perf_fetch_cnt); end
        if (perf_kill_cnt !== 32'd0)  begin n_err++; $display("FAIL rstw_perf_kill: got %0d want 0", perf_kill_cnt); end
`endif
        repeat (6) @(negedge clk);
        req_log.delete();
        stall       = 1'b0;
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        imem_rvalid = 1'b0;
        wait_fvalid(20, "rstw_deliver");
        n_cmp += 3;
        if (F_pc !== TB_RESET_PC)           begin n_err++; $display("FAIL rstw_first_pc: got %h want %h", F_pc, TB_RESET_PC); end
        if (F_inst !== mem_word(TB_RESET_PC)) begin n_err++; $display("FAIL rstw_first_inst: got %h want %h", F_inst, mem_word(TB_RESET_PC)); end
        if (req_log.size() < 1 || req_log[0] !== TB_RESET_PC) begin
            n_err++; $display("FAIL rstw_first_req: got %h want %h", (req_log.size() > 0) ? req_log[0] : 32'hx, TB_RESET_PC);
        end
    endtask

    // Program-order model: each consumed instruction must be the successor of
    // the previous one, or the redirect target after a jb.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_pc, prev_inst;
        logic        prev_valid, prev_stall, prev_jb;
        int          delivered;
        mem_rand = 1'b1;
        do_reset();
        exp_pc     = TB_RESET_PC;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        prev_jb    = 1'b0;
        prev_pc    = 32'd0;
        prev_inst  = 32'd0;
        delivered  = 0;
        for (int c = 0; c < 2000; c++) begin
            if (prev_stall && prev_valid && !prev_jb) begin
                n_cmp++;
                if (F_valid !== 1'b1 || F_pc !== prev_pc || F_inst !== prev_inst) begin
                    n_err++;
                    $display("FAIL rnd_stall_hold c%0d: got %b/%h/%h want 1/%h/%h", c, F_valid, F_pc, F_inst, prev_pc, prev_inst);
                end
            end
            stall = ($urandom_range(0, 2) == 0);
            jb    = ($urandom_range(0, 24) == 0);
            jb_pc = $urandom & 32'h0000_FFFF;
            if (F_valid === 1'b1 && !stall) begin
                n_cmp++;
                delivered++;
                if (F_pc !== exp_pc || F_inst !== mem_word(exp_pc)) begin
                    n_err++;
                    $display("FAIL rnd_stream c%0d: got %h/%h want %h/%h", c, F_pc, F_inst, exp_pc, mem_word(exp_pc));
                end
                exp_pc = F_pc + 32'd4;
            end
            if (jb) exp_pc = {jb_pc[31:2], 2'b00};
            prev_valid = F_valid;
            prev_stall = stall;
            prev_jb    = jb;
            prev_pc    = F_pc;
            prev_inst  = F_inst;
            @(negedge clk);
        end
        stall    = 1'b0;
        jb       = 1'b0;
        mem_rand = 1'b0;
        n_cmp++;
        if (delivered < 100) begin n_err++; $display("FAIL rnd_progress: got %0d deliveries want >= 100", delivered); end
    endtask

    initial begin
        rst_n = 1'b1;
        stall = 1'b0;
        jb    = 1'b0;
        jb_pc = 32'd0;
        test_reset();
        test_sequential();
        test_stall_hold();
        test_redirect_wait();
        test_jb_with_rvalid();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
